proc_core_param: RTL and testbench

- Parametrised successor of the multi-cycle load/store processor core.
- Fetches one instruction per `pcCounter` value and executes it.
- Instruction set: NOP, SET, GET, LD, ST, ADD-immediate, JMP and HALT.
- Talks to the cache/memory side through the `rwToMem`/`rdEn`/`wtEn` handshake; adds a memory-wait timeout, sticky error codes and a halt state.

---
 rtl/proc_core_param_pkg.sv | 38 +++
 rtl/proc_regfile.sv | 44 ++++
 rtl/proc_core_param.sv | 217 +++++++++++++++++++++
 tb/tb_proc_core_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_core_param_pkg.sv
// Shared encodings for the parametrised load/store core: opcodes, memory
// handshake codes, FSM state codes, error codes and a width helper.
package proc_core_param_pkg;

    // Opcodes (4-bit field; anything above 7 is illegal)
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_SET  = 4'd1;
    localparam logic [3:0] OP_GET  = 4'd2;
    localparam logic [3:0] OP_LD   = 4'd3;
    localparam logic [3:0] OP_ST   = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    // Memory handshake codes driven on rwToMem
    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_RD   = 2'd1;
    localparam logic [1:0] MEM_WT   = 2'd2;

    // CPU states (3-bit, legacy-compatible)
    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_EXE   = 3'd1;
    localparam logic [2:0] ST_MEM   = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // Sticky error codes
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLOP   = 2'd1;
    localparam logic [1:0] ERR_BADREG  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Register-index field width: at least one bit even for tiny files
    function automatic int ridx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/proc_regfile.sv
// REG_NUM x WORD_W register file: one write port, one combinational read
// port, asynchronous clear. Out-of-range indices read as zero and never write.
module proc_regfile #(
    parameter int WORD_W  = 8,
    parameter int REG_NUM = 4,
    parameter int RIDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [RIDX_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [RIDX_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [REG_NUM];
    logic              w_waddr_ok;
    logic              w_raddr_ok;

    assign w_waddr_ok = (32'(i_waddr) < 32'(REG_NUM));
    assign w_raddr_ok = (32'(i_raddr) < 32'(REG_NUM));

    // Register storage: cleared on reset, written when enabled and in range
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_mem[i] <= {WORD_W{1'b0}};
            end
        end else if (i_we && w_waddr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read, guarded against indices past the last register
    always_comb begin
        if (w_raddr_ok) begin
            o_rdata = r_mem[i_raddr];
        end else begin
            o_rdata = {WORD_W{1'b0}};
        end
    end

endmodule

// File: rtl/proc_core_param.sv
// Parametrised multi-cycle load/store core: FETCH -> EXE (-> MEM) -> FETCH,
// with a bounded memory wait, sticky error codes and a sticky halt state.
module proc_core_param
    import proc_core_param_pkg::*;
#(
    parameter  int WORD_W  = 8,
    parameter  int ADDR_W  = 8,
    parameter  int PC_W    = 8,
    parameter  int REG_NUM = 4,
    parameter  int TIMEOUT = 15,
    localparam int RIDX_W  = ridx_width(REG_NUM),
    localparam int INSTR_W = 4 + RIDX_W + WORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pcCounter,
    output logic [WORD_W-1:0]  data,
    output logic [1:0]         rwToMem,
    output logic [ADDR_W-1:0]  addrToMem,
    output logic [WORD_W-1:0]  dataToMem,
    input  logic               rdEn,
    input  logic               wtEn,
    input  logic [WORD_W-1:0]  dataFromMem,
    output logic [1:0]         errCode,
    output logic               halted
);

    // Last MEM wait count before a timeout is declared
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    r_pc;
    logic [WORD_W-1:0]  r_data;
    logic [1:0]         r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_dto;
    logic [1:0]         r_err;
    logic               r_halted;
    logic [7:0]         r_wait;

    logic [3:0]         w_op;
    logic [RIDX_W-1:0]  w_reg;
    logic [WORD_W-1:0]  w_imm;
    logic               w_reg_ok;
    logic [PC_W-1:0]    w_jmp_target;
    logic [WORD_W-1:0]  w_rdata;
    logic               w_we;
    logic [WORD_W-1:0]  w_wdata;
    logic               w_mem_done;

    assign w_op     = r_ir[INSTR_W-1 -: 4];
    assign w_reg    = r_ir[WORD_W +: RIDX_W];
    assign w_imm    = r_ir[WORD_W-1:0];
    assign w_reg_ok = (32'(w_reg) < 32'(REG_NUM));

    // A read completes only on rdEn, a write only on wtEn; the other is ignored
    assign w_mem_done = ((r_rw == MEM_RD) && rdEn) || ((r_rw == MEM_WT) && wtEn);

    // Jump target: truncate the immediate, or zero-extend when PC is wider
    generate
        if (PC_W <= WORD_W) begin : g_jt_trunc
            assign w_jmp_target = w_imm[PC_W-1:0];
        end else begin : g_jt_ext
            assign w_jmp_target = {{(PC_W-WORD_W){1'b0}}, w_imm};
        end
    endgenerate

    proc_regfile #(
        .WORD_W (WORD_W),
        .REG_NUM(REG_NUM),
        .RIDX_W (RIDX_W)
    ) u_regfile (
        .clk    (clk),
        .rst    (reset),
        .i_we   (w_we),
        .i_waddr(w_reg),
        .i_wdata(w_wdata),
        .i_raddr(w_reg),
        .o_rdata(w_rdata)
    );

    // Register-file write: SET/ADD in EXE, load data on the completing MEM edge
    always_comb begin
        w_we    = 1'b0;
        w_wdata = {WORD_W{1'b0}};
        case (r_state)
            ST_EXE: begin
                if (!w_op[3] && w_reg_ok) begin
                    case (w_op)
                        OP_SET: begin
                            w_we    = 1'b1;
                            w_wdata = w_imm;
                        end
                        OP_ADD: begin
                            w_we    = 1'b1;
                            w_wdata = w_rdata + w_imm;
                        end
                        default: begin
                            w_we    = 1'b0;
                            w_wdata = {WORD_W{1'b0}};
                        end
                    endcase
                end else begin
                    w_we = 1'b0;
                end
            end
            ST_MEM: begin
                if ((r_rw == MEM_RD) && rdEn) begin
                    w_we    = 1'b1;
                    w_wdata = dataFromMem;
                end else begin
                    w_we = 1'b0;
                end
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // Main FSM and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_ir     <= {INSTR_W{1'b0}};
            r_pc     <= {PC_W{1'b0}};
            r_data   <= {WORD_W{1'b0}};
            r_rw     <= MEM_IDLE;
            r_addr   <= {ADDR_W{1'b0}};
            r_dto    <= {WORD_W{1'b0}};
            r_err    <= ERR_NONE;
            r_halted <= 1'b0;
            r_wait   <= 8'd0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_ir    <= instruction;
                    r_pc    <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
                    r_rw    <= MEM_IDLE;
                    r_state <= ST_EXE;
                end
                ST_EXE: begin
                    if (w_op[3]) begin
                        r_err   <= ERR_ILLOP;
                        r_state <= ST_ERR;
                    end else if (!w_reg_ok) begin
                        r_err   <= ERR_BADREG;
                        r_state <= ST_ERR;
                    end else begin
                        case (w_op)
                            OP_GET: begin
                                r_data  <= w_rdata;
                                r_state <= ST_FETCH;
                            end
                            OP_JMP: begin
                                r_pc    <= w_jmp_target;
                                r_state <= ST_FETCH;
                            end
                            OP_LD: begin
                                r_rw    <= MEM_RD;
                                r_addr  <= w_imm[ADDR_W-1:0];
                                r_wait  <= 8'd0;
                                r_state <= ST_MEM;
                            end
                            OP_ST: begin
                                r_rw    <= MEM_WT;
                                r_addr  <= w_imm[ADDR_W-1:0];
                                r_dto   <= w_rdata;
                                r_wait  <= 8'd0;
                                r_state <= ST_MEM;
                            end
                            OP_HALT: begin
                                r_halted <= 1'b1;
                                r_state  <= ST_HALT;
                            end
                            default: begin
                                // NOP, SET, ADD: regfile side handles writes
                                r_state <= ST_FETCH;
                            end
                        endcase
                    end
                end
                ST_MEM: begin
                    if (w_mem_done) begin
                        r_rw    <= MEM_IDLE;
                        r_state <= ST_FETCH;
                    end else if (r_wait == TO_LAST) begin
                        r_err   <= ERR_TIMEOUT;
                        r_rw    <= MEM_IDLE;
                        r_state <= ST_ERR;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_HALT, ST_ERR: begin
                    r_rw <= MEM_IDLE;
                end
                default: begin
                    r_rw    <= MEM_IDLE;
                    r_err   <= ERR_ILLOP;
                    r_state <= ST_ERR;
                end
            endcase
        end
    end

    assign pcCounter = r_pc;
    assign data      = r_data;
    assign rwToMem   = r_rw;
    assign addrToMem = r_addr;
    assign dataToMem = r_dto;
    assign errCode   = r_err;
    assign halted    = r_halted;

endmodule

// File: tb/tb_proc_core_param.sv
// Directed self-checking bench for proc_core_param. A 4-register and a
// 3-register instance run the same program image side by side.
module tb_proc_core_param;
    import proc_core_param_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] prog [256];
    logic        rdEn, wtEn;
    logic [7:0]  dfm;

    logic [13:0] instr1, instr2;
    logic [7:0]  pc1, data1, addr1, dto1;
    logic [1:0]  rw1, err1;
    logic        halt1;
    logic [7:0]  pc2, data2, addr2, dto2;
    logic [1:0]  rw2, err2;
    logic        halt2;

    int checks   = 0;
    int failures = 0;

    assign instr1 = prog[pc1];
    assign instr2 = prog[pc2];

    proc_core_param #(.REG_NUM(4)) dut (
        .clk(clk), .reset(reset), .instruction(instr1), .pcCounter(pc1),
        .data(data1), .rwToMem(rw1), .addrToMem(addr1), .dataToMem(dto1),
        .rdEn(rdEn), .wtEn(wtEn), .dataFromMem(dfm), .errCode(err1),
        .halted(halt1)
    );

    proc_core_param #(.REG_NUM(3)) dut3 (
        .clk(clk), .reset(reset), .instruction(instr2), .pcCounter(pc2),
        .data(data2), .rwToMem(rw2), .addrToMem(addr2), .dataToMem(dto2),
        .rdEn(rdEn), .wtEn(wtEn), .dataFromMem(dfm), .errCode(err2),
        .halted(halt2)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] enc(input logic [3:0] op, input logic [1:0] r,
                                        input logic [7:0] imm);
        return {op, r, imm};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic begin_reset();
        reset = 1'b1;
        rdEn  = 1'b0;
        wtEn  = 1'b0;
        dfm   = 8'h00;
        @(negedge clk);
        for (int i = 0; i < 256; i++) prog[i] = enc(OP_NOP, 2'd0, 8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pc"},   32'(pc1),   32'h0);
        check_eq({tag, "_data"}, 32'(data1), 32'h0);
        check_eq({tag, "_rw"},   32'(rw1),   32'h0);
        check_eq({tag, "_addr"}, 32'(addr1), 32'h0);
        check_eq({tag, "_dto"},  32'(dto1),  32'h0);
        check_eq({tag, "_err"},  32'(err1),  32'h0);
        check_eq({tag, "_halt"}, 32'(halt1), 32'h0);
    endtask

    initial begin
        // Reset values
        begin_reset();
        check_reset_outputs("rst");

        // SET R1,0x5A ; GET R1 -> data on 4th edge
        prog[0] = enc(OP_SET, 2'd1, 8'h5A);
        prog[1] = enc(OP_GET, 2'd1, 8'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("get_early_data", 32'(data1), 32'h00);
        @(negedge clk);
        check_eq("get_data", 32'(data1), 32'h5A);
        check_eq("get_pc",   32'(pc1),   32'h02);

        // SET R2,0xF0 ; ADD R2,0x20 ; GET R2 -> wraps to 0x10
        begin_reset();
        prog[0] = enc(OP_SET, 2'd2, 8'hF0);
        prog[1] = enc(OP_ADD, 2'd2, 8'h20);
        prog[2] = enc(OP_GET, 2'd2, 8'h00);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("add_wrap_data", 32'(data1), 32'h10);
        check_eq("add_wrap_pc",   32'(pc1),   32'h03);

        // Registers are cleared by reset: ADD R2,0x01 ; GET R2 -> 0x01
        begin_reset();
        prog[0] = enc(OP_ADD, 2'd2, 8'h01);
        prog[1] = enc(OP_GET, 2'd2, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("regs_cleared", 32'(data1), 32'h01);

        // LD R0,0x33 with rdEn on the 3rd MEM cycle; wtEn during LD ignored
        begin_reset();
        prog[0] = enc(OP_LD,  2'd0, 8'h33);
        prog[1] = enc(OP_GET, 2'd0, 8'h00);
        dfm     = 8'hC3;
        reset   = 1'b0;
        @(negedge clk);
        check_eq("ld_fetch_rw", 32'(rw1), 32'(MEM_IDLE));
        @(negedge clk);
        check_eq("ld_mem1_rw",  32'(rw1),   32'(MEM_RD));
        check_eq("ld_addr",     32'(addr1), 32'h33);
        wtEn = 1'b1;
        @(negedge clk);
        check_eq("ld_mem2_rw",  32'(rw1), 32'(MEM_RD));
        wtEn = 1'b0;
        @(negedge clk);
        check_eq("ld_mem3_rw",  32'(rw1), 32'(MEM_RD));
        rdEn = 1'b1;
        @(negedge clk);
        check_eq("ld_done_rw",  32'(rw1),  32'(MEM_IDLE));
        check_eq("ld_done_err", 32'(err1), 32'h0);
        rdEn = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("ld_get_data", 32'(data1), 32'hC3);
        check_eq("ld_get_pc",   32'(pc1),   32'h02);

        // ST R1,0x40 never acknowledged -> timeout after 15 MEM cycles;
        // rdEn held high during ST must be ignored
        begin_reset();
        prog[0] = enc(OP_SET, 2'd1, 8'h77);
        prog[1] = enc(OP_ST,  2'd1, 8'h40);
        reset = 1'b0;
        rdEn  = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("st_rw",   32'(rw1),   32'(MEM_WT));
        check_eq("st_addr", 32'(addr1), 32'h40);
        check_eq("st_dto",  32'(dto1),  32'h77);
        repeat (14) @(negedge clk);
        check_eq("st_mem14_rw",  32'(rw1),  32'(MEM_WT));
        check_eq("st_mem14_err", 32'(err1), 32'(ERR_NONE));
        @(negedge clk);
        check_eq("st_to_err", 32'(err1), 32'(ERR_TIMEOUT));
        check_eq("st_to_rw",  32'(rw1),  32'(MEM_IDLE));
        repeat (20) @(negedge clk);
        check_eq("st_hold_err",  32'(err1),  32'(ERR_TIMEOUT));
        check_eq("st_hold_rw",   32'(rw1),   32'(MEM_IDLE));
        check_eq("st_hold_pc",   32'(pc1),   32'h02);
        check_eq("st_hold_addr", 32'(addr1), 32'h40);
        check_eq("st_hold_dto",  32'(dto1),  32'h77);
        rdEn = 1'b0;

        // Illegal opcode 0xA -> errCode 1, PC frozen
        begin_reset();
        prog[0] = enc(4'hA, 2'd0, 8'h00);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("illop_err", 32'(err1), 32'(ERR_ILLOP));
        check_eq("illop_pc",  32'(pc1),  32'h01);
        repeat (5) @(negedge clk);
        check_eq("illop_hold_err", 32'(err1), 32'(ERR_ILLOP));
        check_eq("illop_hold_pc",  32'(pc1),  32'h01);

        // Register 3: legal with 4 registers, bad with 3
        begin_reset();
        prog[0] = enc(OP_SET, 2'd2, 8'h11);
        prog[1] = enc(OP_SET, 2'd3, 8'h99);
        prog[2] = enc(OP_GET, 2'd3, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("badreg_err3", 32'(err2), 32'(ERR_BADREG));
        check_eq("badreg_pc3",  32'(pc2),  32'h02);
        check_eq("badreg_err4", 32'(err1), 32'(ERR_NONE));
        repeat (2) @(negedge clk);
        check_eq("badreg_data4",    32'(data1), 32'h99);
        check_eq("badreg_hold_pc3", 32'(pc2),   32'h02);
        check_eq("badreg_hold_e3",  32'(err2),  32'(ERR_BADREG));

        // JMP 0x07 ; HALT at 7 -> PC 0x08, halted sticky
        begin_reset();
        prog[0] = enc(OP_JMP,  2'd0, 8'h07);
        prog[7] = enc(OP_HALT, 2'd0, 8'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("jmp_pc",        32'(pc1),   32'h08);
        check_eq("jmp_halt_early", 32'(halt1), 32'h0);
        @(negedge clk);
        check_eq("halt_flag", 32'(halt1), 32'h1);
        check_eq("halt_pc",   32'(pc1),   32'h08);
        repeat (5) @(negedge clk);
        check_eq("halt_hold_flag", 32'(halt1), 32'h1);
        check_eq("halt_hold_pc",   32'(pc1),   32'h08);
        check_eq("halt_hold_rw",   32'(rw1),   32'(MEM_IDLE));

        // Reset asserted mid-LD clears everything asynchronously
        begin_reset();
        prog[0] = enc(OP_SET, 2'd1, 8'h5A);
        prog[1] = enc(OP_GET, 2'd1, 8'h00);
        prog[2] = enc(OP_LD,  2'd0, 8'h33);
        reset = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("midld_rw",   32'(rw1),   32'(MEM_RD));
        check_eq("midld_data", 32'(data1), 32'h5A);
        check_eq("midld_addr", 32'(addr1), 32'h33);
        check_eq("midld_pc",   32'(pc1),   32'h03);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
